// File: rtl/prog_logic_cell.sv
// prog_logic_cell -- NCH independent NIN-input lookup-table logic channels
// behind a one-entry registered valid/ready stage, reprogrammed through a
// serial truth-table loader.
//
// Optional feature macro: PLC_CFG_READBACK_EN
//   defined   : cfg_start preloads the shadow register with the active table,
//               and cfg_dout streams it out LSB-first while the new table
//               shifts in.
//   undefined : no preload; cfg_dout is tied to 0.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   in_data valid this cycle
//   in_ready   stage can accept in_data this cycle
//   in_data    channel c operand at [c*NIN +: NIN]
//   out_valid  out_data holds a result
//   out_ready  consumer takes out_data this cycle
//   out_data   bit c = channel c result
//   cfg_start  single-cycle pulse that (re)starts a table load
//   cfg_valid  cfg_bit valid this cycle
//   cfg_bit    serial truth-table bit, first bit lands at table bit 0
//   cfg_busy   load in progress
//   cfg_done   single-cycle pulse after the new table is committed
//   cfg_dout   serial readback bit
module prog_logic_cell #(
  parameter int NIN = 3,
  parameter int NCH = 2,
  parameter logic [2**NIN-1:0] INIT_TT = 8'h8F
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*NIN-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH-1:0]       out_data,
  input  logic                 cfg_start,
  input  logic                 cfg_valid,
  input  logic                 cfg_bit,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic                 cfg_dout
);

  localparam int TTC = 2**NIN;
  localparam int TTW = NCH*TTC;
  localparam int CW  = $clog2(TTW+1);

  typedef enum logic {IDLE, LOAD} cfg_state_e;

  cfg_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TTW-1:0]    shadow_q, shadow_d;
  logic [TTW-1:0]    active_tt_q, active_tt_d;
  logic              done_q, done_d;
  logic              out_valid_q, out_valid_d;
  logic [NCH-1:0]    out_data_q, out_data_d;
  logic [TTW-1:0]    shifted;
  logic [TTC-1:0]    ch_tt;
  logic              xfer;

  // Register bank; reset abandons any load and drops a pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      active_tt_q <= {NCH{INIT_TT}};
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      active_tt_q <= active_tt_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Loader FSM. cfg_start wins over cfg_valid so a restart never keeps a
  // bit from its own cycle; the final bit commits the post-shift shadow in
  // one step so evaluation never sees a half-written table.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    active_tt_d = active_tt_q;
    done_d      = 1'b0;
    shifted     = {cfg_bit, shadow_q[TTW-1:1]};
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
`ifdef PLC_CFG_READBACK_EN
          shadow_d = active_tt_q;
`endif
        end
      end
      LOAD: begin
        if (cfg_start) begin
          cnt_d = '0;
`ifdef PLC_CFG_READBACK_EN
          shadow_d = active_tt_q;
`endif
        end else if (cfg_valid) begin
          shadow_d = shifted;
          if (cnt_q == CW'(TTW-1)) begin
            active_tt_d = shifted;
            done_d      = 1'b1;
            cnt_d       = '0;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Evaluation stage. Lookups use the registered table, so a transfer in
  // the commit cycle still sees the old contents.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ch_tt       = '0;
    in_ready    = !out_valid_q || out_ready;
    xfer        = in_valid && in_ready;
    if (xfer) begin
      out_valid_d = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        ch_tt         = active_tt_q[c*TTC +: TTC];
        out_data_d[c] = ch_tt[in_data[c*NIN +: NIN]];
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cfg_busy  = (state_q == LOAD);
  assign cfg_done  = done_q;

`ifdef PLC_CFG_READBACK_EN
  assign cfg_dout = shadow_q[0];
`else
  assign cfg_dout = 1'b0;
`endif

endmodule

// File: tb/tb_prog_logic_cell.sv
// Testbench for prog_logic_cell (NIN=3, NCH=2, INIT_TT=8'h8F). A behavioural
// model tracks the truth table as a plain bit array filled by bit position
// and the output stage as a valid flag plus lookup; a compare process checks
// the DUT against it every cycle, and directed literal checks pin the model.
module tb_prog_logic_cell;

  localparam int TTC = 8;
  localparam int TTW = 16;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_bit;
  logic       cfg_busy;
  logic       cfg_done;
  logic       cfg_dout;

  int total = 0;
  int bad = 0;
  int done_count = 0;

  prog_logic_cell #(.NIN(3), .NCH(2), .INIT_TT(8'h8F)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_dout(cfg_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [TTW-1:0] m_table;
  logic [TTW-1:0] m_new;
  logic [TTW-1:0] m_old;
  logic [TTW-1:0] m_commit;
  int             m_count;
  logic           m_loading;
  logic           m_done;
  logic           m_valid;
  logic [1:0]     m_data;
  logic           m_idle_dout;
  logic           m_dout;

  function automatic logic [TTW-1:0] with_bit(input logic [TTW-1:0] v, input int i, input logic b);
    logic [TTW-1:0] r;
    r = v;
    r[i] = b;
    return r;
  endfunction

  assign m_commit = with_bit(m_new, m_count, cfg_bit);

`ifdef PLC_CFG_READBACK_EN
  assign m_dout = m_loading ? m_old[m_count] : m_idle_dout;
`else
  assign m_dout = 1'b0;
`endif

  // Model: received bits are written by position; the last one commits.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_table     <= {2{8'h8F}};
      m_new       <= '0;
      m_old       <= '0;
      m_count     <= 0;
      m_loading   <= 1'b0;
      m_done      <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_idle_dout <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (cfg_start) begin
        m_loading <= 1'b1;
        m_count   <= 0;
        m_old     <= m_table;
      end else if (m_loading && cfg_valid) begin
        if (m_count == TTW-1) begin
          m_table     <= m_commit;
          m_idle_dout <= m_commit[0];
          m_loading   <= 1'b0;
          m_done      <= 1'b1;
          m_count     <= 0;
        end else begin
          m_new   <= m_commit;
          m_count <= m_count + 1;
        end
      end
      if (in_valid && (!m_valid || out_ready)) begin
        m_valid <= 1'b1;
        for (int c = 0; c < 2; c++)
          m_data[c] <= m_table[c*TTC + ((int'(in_data) >> (c*3)) & 7)];
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) checkOutput("out_data", 32'(out_data), 32'(m_data));
      checkOutput("cfg_busy", 32'(cfg_busy), 32'(m_loading));
      checkOutput("cfg_done", 32'(cfg_done), 32'(m_done));
      checkOutput("cfg_dout", 32'(cfg_dout), 32'(m_dout));
      if (cfg_done) done_count = done_count + 1;
    end
  end

  task automatic applyStimulus(input logic iv, input logic [5:0] id, input logic ordy,
                               input logic cs, input logic cv, input logic cb);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    cfg_start = cs;
    cfg_valid = cv;
    cfg_bit   = cb;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 6'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  logic [15:0] rb;
  logic [15:0] pattern;
  int          dc0;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_cfg_busy", 32'(cfg_busy), 32'd0);
    checkOutput("rst_cfg_done", 32'(cfg_done), 32'd0);
    checkOutput("rst_cfg_dout", 32'(cfg_dout), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Default table lookup
    applyStimulus(1'b1, 6'b000_100, 1'b1, 1'b0, 1'b0, 1'b0);
    idleCycle();
    @(negedge clk);
    checkOutput("init_valid", 32'(out_valid), 32'd1);
    checkOutput("init_data", 32'(out_data), 32'b10);
    idleCycle();

    // Backpressure: held result, then take-and-refill in one cycle
    applyStimulus(1'b1, 6'b000_100, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 6'b111_000, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_hold_data", 32'(out_data), 32'b10);
    end
    applyStimulus(1'b1, 6'b111_000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
    idleCycle();
    @(negedge clk);
    checkOutput("bp_new_data", 32'(out_data), 32'b11);
    checkOutput("bp_new_valid", 32'(out_valid), 32'd1);
    idleCycle();

    // Load 16'h00FF, capturing readback of the reset table
    pattern = 16'h00FF;
    dc0 = done_count;
    applyStimulus(1'b0, 6'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 6'b0, 1'b1, 1'b0, 1'b1, pattern[i]);
      @(negedge clk);
      rb[i] = cfg_dout;
    end
`ifdef PLC_CFG_READBACK_EN
    checkOutput("readback", 32'(rb), 32'h8F8F);
`else
    checkOutput("readback", 32'(rb), 32'h0000);
`endif
    idleCycle();
    @(negedge clk);
    checkOutput("load_done", 32'(cfg_done), 32'd1);
    checkOutput("load_busy", 32'(cfg_busy), 32'd0);
    applyStimulus(1'b1, 6'b111_000, 1'b1, 1'b0, 1'b0, 1'b0);
    idleCycle();
    @(negedge clk);
    checkOutput("load_data", 32'(out_data), 32'b01);
    checkOutput("load_done_once", 32'(done_count - dc0), 32'd1);

    // Restart after 7 bits, then full load of ones; commit-cycle transfer
    dc0 = done_count;
    applyStimulus(1'b0, 6'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 6'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 6'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 6'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 6'b000_000, 1'b1, 1'b0, 1'b1, 1'b1);
    idleCycle();
    @(negedge clk);
    checkOutput("commit_old_data", 32'(out_data), 32'b01);
    checkOutput("commit_done", 32'(cfg_done), 32'd1);
    applyStimulus(1'b1, 6'b101_010, 1'b1, 1'b0, 1'b0, 1'b0);
    idleCycle();
    @(negedge clk);
    checkOutput("ones_data", 32'(out_data), 32'b11);
    checkOutput("restart_done_once", 32'(done_count - dc0), 32'd1);

    // Reset mid-load
    dc0 = done_count;
    applyStimulus(1'b0, 6'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 6'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idleCycle();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_busy", 32'(cfg_busy), 32'd0);
    applyStimulus(1'b1, 6'b000_100, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'b111_000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rst_mid_data0", 32'(out_data), 32'b10);
    idleCycle();
    @(negedge clk);
    checkOutput("rst_mid_data1", 32'(out_data), 32'b11);
    checkOutput("rst_mid_no_done", 32'(done_count - dc0), 32'd0);
    idleCycle();
    idleCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_logic_cell.md
PROG_LOGIC_CELL -- requirements
Module: prog_logic_cell

Interface
REQ-001 The block SHALL have parameter NIN, default 3, meaning inputs per channel (range 1..6).
REQ-002 The block SHALL have parameter NCH, default 2, meaning independent logic channels (range 1..8).
REQ-003 The block SHALL have parameter INIT_TT, default 8'h8F (width 2**NIN), meaning the per-channel reset truth table, replicated to all channels; 8'h8F implements (A&B)|~C with index {C,B,A}.
REQ-004 The block SHALL derive local TTW = NCH*2**NIN, the total truth-table bits.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  in_data valid this cycle.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 in_data  input  NCH*NIN  channel c operand at [c*NIN +: NIN].
REQ-010 out_valid  output  1  out_data holds a result.
REQ-011 out_ready  input  1  consumer takes out_data this cycle.
REQ-012 out_data  output  NCH  bit c = channel c result.
REQ-013 cfg_start  input  1  single-cycle pulse starting a table load.
REQ-014 cfg_valid  input  1  cfg_bit valid this cycle.
REQ-015 cfg_bit  input  1  serial truth-table bit.
REQ-016 cfg_busy  output  1  load in progress.
REQ-017 cfg_done  output  1  single-cycle pulse on table commit.
REQ-018 cfg_dout  output  1  serial readback bit.

Function
REQ-019 Evaluation SHALL be a one-entry registered stage: a transfer occurs when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-020 On transfer, out_data[c] SHALL become active_tt[c*2**NIN + in_data[c*NIN +: NIN]] and out_valid SHALL be 1 on the next cycle (latency 1).
REQ-021 out_valid SHALL clear when out_ready is 1 and no new transfer occurs in the same cycle; out_data SHALL hold stable while out_valid && !out_ready.
REQ-022 Configuration FSM SHALL have states IDLE and LOAD; cfg_busy = (state == LOAD).
REQ-023 IDLE -> LOAD on cfg_start; bit counter SHALL clear to 0.
REQ-024 In LOAD, each cycle with cfg_valid SHALL shift shadow <= {cfg_bit, shadow[TTW-1:1]} and increment the counter; cycles without cfg_valid SHALL hold.
REQ-025 On the cycle the TTW-th bit is shifted, active_tt SHALL load the post-shift shadow value atomically, cfg_done SHALL pulse next cycle, and FSM SHALL return to IDLE; first bit shifted thus lands at active_tt[0].
REQ-026 cfg_start during LOAD SHALL restart: counter cleared, partial bits discarded, active_tt unchanged.
REQ-027 Evaluation SHALL continue during LOAD using the old active_tt; a transfer in the commit cycle SHALL use the old table, transfers from the next cycle the new table.
REQ-028 cfg_valid in IDLE SHALL be ignored.

Reset
REQ-029 While rst is 1: state IDLE, counter 0, shadow 0, active_tt = INIT_TT replicated NCH times, out_valid 0, out_data 0, cfg_done 0, cfg_dout 0.
REQ-030 rst asserted mid-LOAD SHALL abandon the load with no partial commit; rst asserted with out_valid 1 SHALL drop the pending result.

Configuration
REQ-031 Macro PLC_CFG_READBACK_EN SHALL control table readback.
REQ-032 With PLC_CFG_READBACK_EN defined: on cfg_start shadow SHALL load active_tt, and cfg_dout SHALL equal shadow[0], so the previous table streams out LSB-first as the new one shifts in.
REQ-033 Without PLC_CFG_READBACK_EN: shadow SHALL not be preloaded on cfg_start and cfg_dout SHALL be constant 0.

Verification (NIN=3, NCH=2, INIT_TT=8'h8F)
REQ-034 Post-reset, in_valid=1 with in_data=6'b000_100 (ch0 C=1,A=B=0; ch1 all 0), out_ready=1 -> next cycle out_valid=1, out_data=2'b10.
REQ-035 cfg_start, then 16 cfg_valid bits of 16'h00FF LSB-first -> cfg_done pulses once; in_data=6'b111_000 -> out_data=2'b01; cfg_busy low after commit.
REQ-036 out_ready=0 with out_valid=1 and in_valid=1 -> in_ready=0, out_data stable over 5 cycles; raise out_ready -> result taken and new transfer same cycle.
REQ-037 cfg_start after 7 bits, then a full 16-bit load of 16'hFFFF -> only one cfg_done, all results 2'b11 afterwards; transfer in commit cycle returns old-table result.
REQ-038 rst pulse after 10 of 16 bits -> table stays 8'h8F per channel, cfg_busy=0, no cfg_done.
REQ-039 With PLC_CFG_READBACK_EN: load following reset -> cfg_dout over 16 cfg_valid cycles equals 16'h8F8F LSB-first; without macro cfg_dout stays 0.
